// File: rtl/core_pkg.sv
// Shared types for the PC sequencer: FSM state, trap cause codes,
// next-PC selection kinds and the default sequential step.
package core_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_TRAP_ENTRY = 2'd1,
        ST_HALT       = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_EXT      = 2'd1,
        CAUSE_MISALIGN = 2'd2
    } cause_t;

    // Which rule won the next-PC priority decision in RUN
    typedef enum logic [2:0] {
        SEL_SEQ      = 3'd0,
        SEL_BRANCH   = 3'd1,
        SEL_JUMP     = 3'd2,
        SEL_MRET     = 3'd3,
        SEL_HOLD     = 3'd4,
        SEL_HALT     = 3'd5,
        SEL_MISALIGN = 3'd6,
        SEL_TRAP     = 3'd7
    } sel_t;

    localparam int unsigned STEP_DEFAULT = 4;

    // True when the selection diverts execution to the trap vector
    function automatic logic is_trap_sel(input sel_t s);
        return (s == SEL_TRAP) || (s == SEL_MISALIGN);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux used while the sequencer is in RUN.
// Priority: trap > misaligned redirect > halt > stall > mret > jump > branch > increment.
module pc_next_sel
    import core_pkg::*;
#(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int unsigned     STEP        = STEP_DEFAULT
) (
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] epc,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            halt,
    output logic [XLEN-1:0] next_pc,
    output sel_t            sel
);

    logic misaligned;

    // Only the redirect that would actually be taken is alignment-checked;
    // stall does not mask it, so a bad target still traps while stalled.
    always_comb begin
        misaligned = 1'b0;
        if (jump) begin
            misaligned = |jump_target[1:0];
        end else if (branch_taken) begin
            misaligned = |branch_target[1:0];
        end

        sel     = SEL_SEQ;
        next_pc = pc + XLEN'(STEP);
        if (trap) begin
            sel     = SEL_TRAP;
            next_pc = TRAP_VECTOR;
        end else if (misaligned) begin
            sel     = SEL_MISALIGN;
            next_pc = TRAP_VECTOR;
        end else if (halt) begin
            sel     = SEL_HALT;
            next_pc = pc;
        end else if (stall) begin
            sel     = SEL_HOLD;
            next_pc = pc;
        end else if (mret) begin
            sel     = SEL_MRET;
            next_pc = epc;
        end else if (jump) begin
            sel     = SEL_JUMP;
            next_pc = jump_target;
        end else if (branch_taken) begin
            sel     = SEL_BRANCH;
            next_pc = branch_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered PC with branch/jump redirects,
// trap entry with saved EPC/cause, mret return and a halt/resume state.
module pc_sequencer
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned     STEP         = STEP_DEFAULT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            jump,
    input  logic [XLEN-1:0] jump_target,
    input  logic            trap,
    input  logic            mret,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] PC_out,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic [1:0]      cause,
    output logic [1:0]      state
);

    state_t          st;
    cause_t          cause_q;
    sel_t            sel;
    logic [XLEN-1:0] next_pc;

    assign state = st;
    assign cause = cause_q;

    pc_next_sel #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .STEP        (STEP)
    ) u_next_sel (
        .pc            (PC_out),
        .epc           (epc),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .halt          (halt),
        .next_pc       (next_pc),
        .sel           (sel)
    );

    // FSM and all architectural registers; pc_valid is registered from the next state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            PC_out   <= RESET_VECTOR;
            epc      <= '0;
            cause_q  <= CAUSE_NONE;
            st       <= ST_RUN;
            pc_valid <= 1'b1;
        end else begin
            unique case (st)
                ST_RUN: begin
                    if (is_trap_sel(sel)) begin
                        epc      <= PC_out;
                        cause_q  <= (sel == SEL_TRAP) ? CAUSE_EXT : CAUSE_MISALIGN;
                        PC_out   <= next_pc;
                        st       <= ST_TRAP_ENTRY;
                        pc_valid <= 1'b0;
                    end else if (sel == SEL_HALT) begin
                        st       <= ST_HALT;
                        pc_valid <= 1'b0;
                    end else begin
                        PC_out <= next_pc;
                        if (sel == SEL_MRET) begin
                            cause_q <= CAUSE_NONE;
                        end
                    end
                end
                ST_TRAP_ENTRY: begin
                    // One bubble cycle, then fetch from the trap vector already in PC_out
                    st       <= ST_RUN;
                    pc_valid <= 1'b1;
                end
                ST_HALT: begin
                    if (resume) begin
                        st       <= ST_RUN;
                        pc_valid <= 1'b1;
                    end
                end
                default: begin
                    st       <= ST_RUN;
                    pc_valid <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed table of vectors followed by
// randomized stimulus compared against a behavioural model.
module tb_pc_sequencer;

    typedef struct packed {
        logic        rn;
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic        trap;
        logic        mret;
        logic        halt;
        logic        resume;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_epc;
        logic [1:0]  e_cause;
        logic [1:0]  e_state;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic        trap = 1'b0;
    logic        mret = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] PC_out;
    logic        pc_valid;
    logic [31:0] epc;
    logic [1:0]  cause;
    logic [1:0]  state;

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state: 0 running, 1 trap bubble, 2 halted
    logic [31:0] m_pc = '0;
    logic [31:0] m_epc = '0;
    int          m_cause = 0;
    int          m_state = 0;

    vec_t tbl[$];

    pc_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .trap          (trap),
        .mret          (mret),
        .halt          (halt),
        .resume        (resume),
        .PC_out        (PC_out),
        .pc_valid      (pc_valid),
        .epc           (epc),
        .cause         (cause),
        .state         (state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic rn, input logic st, input logic br, input logic [31:0] bt,
        input logic j, input logic [31:0] jt, input logic tr, input logic mr,
        input logic hl, input logic rs,
        input logic [31:0] pc, input logic v, input logic [31:0] ep,
        input logic [1:0] c, input logic [1:0] s);
        vec_t r;
        r.rn = rn; r.stall = st; r.br = br; r.bt = bt; r.j = j; r.jt = jt;
        r.trap = tr; r.mret = mr; r.halt = hl; r.resume = rs;
        r.e_pc = pc; r.e_valid = v; r.e_epc = ep; r.e_cause = c; r.e_state = s;
        return r;
    endfunction

    function automatic vec_t free_run(input logic [31:0] pc, input logic [31:0] ep,
                                      input logic [1:0] c);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, pc, 1, ep, c, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset_n       = v.rn;
        stall         = v.stall;
        branch_taken  = v.br;
        branch_target = v.bt;
        jump          = v.j;
        jump_target   = v.jt;
        trap          = v.trap;
        mret          = v.mret;
        halt          = v.halt;
        resume        = v.resume;
        @(posedge clk);
        #1;
    endtask

    // Architectural rules applied to one clock edge
    task automatic model_step(input vec_t v);
        logic        redirect;
        logic [31:0] tgt;
        if (!v.rn) begin
            m_pc = 32'h0; m_epc = 32'h0; m_cause = 0; m_state = 0;
            return;
        end
        if (m_state == 1) begin
            m_state = 0;
        end else if (m_state == 2) begin
            if (v.resume) m_state = 0;
        end else begin
            redirect = v.j || v.br;
            tgt = v.j ? v.jt : v.bt;
            if (v.trap || (redirect && (tgt % 4 != 0))) begin
                m_epc   = m_pc;
                m_cause = v.trap ? 1 : 2;
                m_pc    = 32'h100;
                m_state = 1;
            end else if (v.halt) begin
                m_state = 2;
            end else if (!v.stall) begin
                if (v.mret) begin
                    m_pc = m_epc;
                    m_cause = 0;
                end else if (redirect) begin
                    m_pc = tgt;
                end else begin
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    function automatic logic [31:0] rand_target();
        logic [31:0] t;
        t = $urandom;
        t[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    initial begin
        // Directed sequence: reset, increments, redirects, traps, halt, wrap, reset corners
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0));
        tbl.push_back(free_run(32'h4, 32'h0, 0));
        tbl.push_back(free_run(32'h8, 32'h0, 0));
        tbl.push_back(free_run(32'hC, 32'h0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h80, 1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 32'h0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'h42, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h40, 2, 1));
        tbl.push_back(free_run(32'h100, 32'h40, 2));
        tbl.push_back(free_run(32'h104, 32'h40, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h40, 1, 32'h40, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h40, 1, 32'h40, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 1, 32'h200, 0, 0, 0, 0, 32'h40, 1, 32'h40, 0, 0));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h40, 1, 1));
        tbl.push_back(free_run(32'h100, 32'h40, 1));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h10, 0, 0, 0, 0, 32'h10, 1, 32'h40, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h10, 0, 32'h40, 1, 2));
        for (int k = 0; k < 4; k++)
            tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h10, 0, 32'h40, 1, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h10, 1, 32'h40, 1, 0));
        tbl.push_back(free_run(32'h14, 32'h40, 1));
        tbl.push_back(mk(1, 0, 1, 32'h80, 0, 0, 0, 0, 0, 0, 32'h80, 1, 32'h40, 1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h40, 1, 0));
        tbl.push_back(free_run(32'h0, 32'h40, 1));
        tbl.push_back(free_run(32'h4, 32'h40, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h100, 0, 32'h4, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0));
        tbl.push_back(free_run(32'h4, 32'h0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 32'h41, 0, 0, 1, 0, 32'h100, 0, 32'h4, 2, 1));
        tbl.push_back(free_run(32'h100, 32'h4, 2));
        tbl.push_back(mk(1, 0, 1, 32'h90, 1, 32'h80, 0, 1, 0, 0, 32'h4, 1, 32'h4, 0, 0));
        tbl.push_back(mk(1, 1, 1, 32'h43, 0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h4, 2, 1));
        tbl.push_back(free_run(32'h100, 32'h4, 2));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h104, 1, 32'h4, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h104, 0, 32'h4, 2, 2));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i]);
            chk($sformatf("row%0d pc", i), PC_out, tbl[i].e_pc);
            chk($sformatf("row%0d valid", i), 32'(pc_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d epc", i), epc, tbl[i].e_epc);
            chk($sformatf("row%0d cause", i), 32'(cause), 32'(tbl[i].e_cause));
            chk($sformatf("row%0d state", i), 32'(state), 32'(tbl[i].e_state));
        end

        // Randomized phase against the behavioural model, starting from reset
        for (int n = 0; n < 400; n++) begin
            vec_t v;
            v = '0;
            v.rn     = (n == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);
            v.stall  = ($urandom_range(0, 4) == 0);
            v.br     = ($urandom_range(0, 3) == 0);
            v.bt     = rand_target();
            v.j      = ($urandom_range(0, 5) == 0);
            v.jt     = rand_target();
            v.trap   = ($urandom_range(0, 15) == 0);
            v.mret   = ($urandom_range(0, 7) == 0);
            v.halt   = ($urandom_range(0, 15) == 0);
            v.resume = ($urandom_range(0, 3) == 0);
            apply(v);
            model_step(v);
            chk($sformatf("rnd%0d pc", n), PC_out, m_pc);
            chk($sformatf("rnd%0d valid", n), 32'(pc_valid), (m_state == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rnd%0d epc", n), epc, m_epc);
            chk($sformatf("rnd%0d cause", n), 32'(cause), 32'(m_cause));
            chk($sformatf("rnd%0d state", n), 32'(state), 32'(m_state));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
